// File: rtl/decode_pipeline_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipeline_unit_if
//  Description : Fetch-to-decode-to-execute bundle for decode_pipeline_unit.
//                The master drives the fetch-side inputs and the control
//                inputs. The slave, which is the decode stage, drives the
//                registered decode bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_pipeline_unit_if #(
    parameter int PC_W = 7
) ();
    // Fetch-side slot and downstream control
    logic            branch_in;
    logic [PC_W-1:0] pc_in;
    logic [31:0]     instr_in;
    logic            stall_in;
    logic            flush_in;

    // Registered decode bundle
    logic            valid_out;
    logic [PC_W-1:0] pc_out;
    logic [31:0]     instr_out;
    logic [3:0]      cond_out;
    logic [1:0]      class_out;
    logic [3:0]      rn_out;
    logic [3:0]      rd_out;
    logic [3:0]      rs_out;
    logic [3:0]      rm_out;
    logic [11:0]     imm12_out;
    logic [15:0]     squash_cnt_out;
    logic [15:0]     stall_cnt_out;

    modport master (
        output branch_in, pc_in, instr_in, stall_in, flush_in,
        input  valid_out, pc_out, instr_out, cond_out, class_out,
               rn_out, rd_out, rs_out, rm_out, imm12_out,
               squash_cnt_out, stall_cnt_out
    );

    modport slave (
        input  branch_in, pc_in, instr_in, stall_in, flush_in,
        output valid_out, pc_out, instr_out, cond_out, class_out,
               rn_out, rd_out, rs_out, rm_out, imm12_out,
               squash_cnt_out, stall_cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipeline_unit.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pipeline_unit
//  Description : Decode pipeline register. It latches the fetch PC and the
//                instruction word, decodes the instruction fields and
//                produces a valid-qualified bundle. It also handles stall
//                hold, the flush squash window and the post-reset squash.
//                Optional macro DECODE_STATS_EN adds two saturating counters:
//                squashed slots and stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_pipeline_unit #(
    parameter int PC_W         = 7,
    parameter int SQUASH_DEPTH = 2
) (
    input  wire                  clk,
    input  wire                  rst,
    decode_pipeline_unit_if.slave bus
);

    localparam logic [2:0] C_DEPTH = 3'(SQUASH_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      squash_k;
    logic            valid_r;
    logic [PC_W-1:0] pc_r;
    logic [31:0]     instr_r;

    // A slot is accepted on any unstalled edge that carries no flush.
    // The slot on a flush edge is discarded.
    logic accept_w;
    assign accept_w = !bus.stall_in && !bus.flush_in;

    // Pipeline state, the squash window and the bundle registers.
    // A flush overrides a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_SQUASH;
            squash_k <= 3'd1;
            valid_r  <= 1'b0;
            pc_r     <= '0;
            instr_r  <= '0;
        end else if (bus.flush_in) begin
            // Reload the window; a flush never accumulates onto the
            // squash slots that remain.
            state    <= ST_SQUASH;
            squash_k <= C_DEPTH;
            valid_r  <= 1'b0;
        end else if (accept_w) begin
            pc_r    <= bus.pc_in;
            instr_r <= bus.instr_in;
            if (state == ST_RUN) begin
                valid_r <= ~bus.branch_in;
            end else begin
                valid_r  <= 1'b0;
                squash_k <= squash_k - 3'd1;
                if (squash_k <= 3'd1) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // The fields are decoded from the latched word, so they track
    // instr_out, bubbles included.
    logic [1:0] class_w;
    always_comb begin
        class_w = 2'b11;
        if (instr_r[27:26] == 2'b00) begin
            class_w = 2'b00;
        end else if (instr_r[27:26] == 2'b01) begin
            class_w = 2'b01;
        end else if (instr_r[27:25] == 3'b101) begin
            class_w = 2'b10;
        end
    end

    assign bus.valid_out = valid_r;
    assign bus.pc_out    = pc_r;
    assign bus.instr_out = instr_r;
    assign bus.cond_out  = instr_r[31:28];
    assign bus.class_out = class_w;
    assign bus.rn_out    = instr_r[19:16];
    assign bus.rd_out    = instr_r[15:12];
    assign bus.rs_out    = instr_r[11:8];
    assign bus.rm_out    = instr_r[3:0];
    assign bus.imm12_out = instr_r[11:0];

`ifdef DECODE_STATS_EN
    logic [15:0] squash_cnt_r;
    logic [15:0] stall_cnt_r;

    // Saturating counters: accepted slots that carry no valid work, and
    // stalled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_cnt_r <= '0;
            stall_cnt_r  <= '0;
        end else begin
            if (accept_w && (bus.branch_in || state == ST_SQUASH) &&
                squash_cnt_r != 16'hFFFF) begin
                squash_cnt_r <= squash_cnt_r + 16'd1;
            end
            if (bus.stall_in && stall_cnt_r != 16'hFFFF) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign bus.squash_cnt_out = squash_cnt_r;
    assign bus.stall_cnt_out  = stall_cnt_r;
`else
    assign bus.squash_cnt_out = 16'h0000;
    assign bus.stall_cnt_out  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_pipeline_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_pipeline_unit
//  Description : Directed self-checking bench for decode_pipeline_unit.
//                The expected values are computed by hand from the
//                instruction encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_pipeline_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    decode_pipeline_unit_if #(.PC_W(7)) bus ();

    decode_pipeline_unit #(
        .PC_W         (7),
        .SQUASH_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count one comparison and report it when the observed value differs
    // from the expected value.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before the outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [6:0] pc,
                         input logic [31:0] ins, input logic st,
                         input logic fl);
        bus.branch_in = br;
        bus.pc_in     = pc;
        bus.instr_in  = ins;
        bus.stall_in  = st;
        bus.flush_in  = fl;
    endtask

    // Stop the run if the stimulus fails to finish.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 7'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) step();
        check_eq("rst_valid", 32'(bus.valid_out), 32'd0);
        check_eq("rst_pc",    32'(bus.pc_out),    32'd0);
        check_eq("rst_instr", bus.instr_out,      32'd0);
        check_eq("rst_class", 32'(bus.class_out), 32'd0);

        // The first slot after reset is a bubble; the second is valid.
        rst = 1'b0;
        drive(1'b0, 7'd4, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("e1_valid", 32'(bus.valid_out), 32'd0);
        check_eq("e1_pc",    32'(bus.pc_out),    32'd4);
        step();
        check_eq("e2_valid", 32'(bus.valid_out), 32'd1);
        check_eq("e2_pc",    32'(bus.pc_out),    32'd4);
        check_eq("e2_cond",  32'(bus.cond_out),  32'hE);
        check_eq("e2_class", 32'(bus.class_out), 32'd0);
        check_eq("e2_rn",    32'(bus.rn_out),    32'd1);
        check_eq("e2_rd",    32'(bus.rd_out),    32'd2);
        check_eq("e2_rs",    32'(bus.rs_out),    32'd0);
        check_eq("e2_rm",    32'(bus.rm_out),    32'd3);
        check_eq("e2_imm",   32'(bus.imm12_out), 32'h003);

        // A load/store word is accepted, then three stalled edges leave
        // the outputs unchanged while new inputs are presented.
        drive(1'b0, 7'd8, 32'hE5912004, 1'b0, 1'b0);
        step();
        check_eq("ls_class", 32'(bus.class_out), 32'd1);
        check_eq("ls_rm",    32'(bus.rm_out),    32'd4);
        drive(1'b0, 7'd12, 32'hE0000000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_valid", 32'(bus.valid_out), 32'd1);
            check_eq("stall_instr", bus.instr_out,      32'hE5912004);
            check_eq("stall_pc",    32'(bus.pc_out),    32'd8);
            check_eq("stall_class", 32'(bus.class_out), 32'd1);
            check_eq("stall_rd",    32'(bus.rd_out),    32'd2);
        end
`ifdef DECODE_STATS_EN
        check_eq("stall_cnt", 32'(bus.stall_cnt_out), 32'd3);
`else
        check_eq("stall_cnt", 32'(bus.stall_cnt_out), 32'd0);
`endif

        // A flush overrides the stall, and two accepts are then squashed.
        drive(1'b0, 7'd12, 32'hE0000000, 1'b1, 1'b1);
        step();
        check_eq("fl_valid", 32'(bus.valid_out), 32'd0);
        drive(1'b0, 7'd16, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("fl_sq1", 32'(bus.valid_out), 32'd0);
        check_eq("fl_pc1", 32'(bus.pc_out),    32'd16);
        step();
        check_eq("fl_sq2", 32'(bus.valid_out), 32'd0);
        step();
        check_eq("fl_run", 32'(bus.valid_out), 32'd1);

        // A second flush inside the window reloads the count to two, so
        // there are three squashed accepts before valid work resumes.
        drive(1'b0, 7'd20, 32'hE0812003, 1'b0, 1'b1);
        step();
        check_eq("df_f1", 32'(bus.valid_out), 32'd0);
        drive(1'b0, 7'd20, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("df_a1", 32'(bus.valid_out), 32'd0);
        drive(1'b0, 7'd20, 32'hE0812003, 1'b0, 1'b1);
        step();
        check_eq("df_f2", 32'(bus.valid_out), 32'd0);
        drive(1'b0, 7'd24, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("df_a2", 32'(bus.valid_out), 32'd0);
        step();
        check_eq("df_a3", 32'(bus.valid_out), 32'd0);
        step();
        check_eq("df_run", 32'(bus.valid_out), 32'd1);

        // A squashed branch slot is a bubble, but its fields still decode.
        drive(1'b1, 7'd28, 32'hEA000010, 1'b0, 1'b0);
        step();
        check_eq("br_valid", 32'(bus.valid_out), 32'd0);
        check_eq("br_class", 32'(bus.class_out), 32'd2);
        check_eq("br_instr", bus.instr_out,      32'hEA000010);
        check_eq("br_pc",    32'(bus.pc_out),    32'd28);
        drive(1'b0, 7'd32, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("br_next", 32'(bus.valid_out), 32'd1);

        // Reset is asserted in the squash window with a stall active. It
        // takes effect asynchronously, and the first accept after release
        // is squashed.
        drive(1'b0, 7'd36, 32'hE0812003, 1'b0, 1'b1);
        step();
        drive(1'b0, 7'd36, 32'hE0812003, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 32'(bus.valid_out), 32'd0);
        check_eq("ar_pc",    32'(bus.pc_out),    32'd0);
        check_eq("ar_instr", bus.instr_out,      32'd0);
        check_eq("ar_cond",  32'(bus.cond_out),  32'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 7'd40, 32'hE0812003, 1'b0, 1'b0);
        step();
        check_eq("ar_sq",  32'(bus.valid_out), 32'd0);
        check_eq("ar_pc2", 32'(bus.pc_out),    32'd40);
        step();
        check_eq("ar_run", 32'(bus.valid_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_pipeline_unit.md
Name: decode_pipeline_unit

Overview:
- Pipeline register and field-decode stage directly downstream of the fetch pipeline unit.
- Consumes the fetch stage's registered PC and squash/branch bit together with the 32-bit instruction word returned by instruction memory.
- Produces a registered, valid-qualified decode bundle for the execute stage.
- Handles stall holding, execute-driven flush with a multi-cycle squash window, and the post-reset squash.

Parameters:
- PC_W, 7, PC width; matches the fetch stage PC.
- SQUASH_DEPTH, 2, number of accepted slots squashed after a flush (1..7).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- branch_in  input  1  fetch-stage squash bit; 1 = incoming slot is a bubble
- pc_in  input  PC_W  fetch-stage PC aligned with instr_in
- instr_in  input  32  instruction word from instruction memory
- stall_in  input  1  hazard stall from downstream; hold outputs
- flush_in  input  1  branch resolved taken in execute; kill in-flight work
- valid_out  output  1  decode bundle valid
- pc_out  output  PC_W  registered PC
- instr_out  output  32  registered instruction
- cond_out  output  4  instr[31:28]
- class_out  output  2  00 data-proc (instr[27:26]=00), 01 load/store (01), 10 branch (instr[27:25]=101), 11 other
- rn_out  output  4  instr[19:16]
- rd_out  output  4  instr[15:12]
- rs_out  output  4  instr[11:8]
- rm_out  output  4  instr[3:0]
- imm12_out  output  12  instr[11:0]
- squash_cnt_out  output  16  squashed-slot count (optional feature)
- stall_cnt_out  output  16  stall-cycle count (optional feature)

Behaviour:
- Reset: all outputs 0; state = SQUASH; squash counter = 1, so the first slot after reset is a bubble.
- Latency: 1 cycle. Inputs sampled at clock edge N appear on the outputs after edge N.
- Upstream contract: while stall_in=1, fetch and instruction memory hold pc_in, instr_in and branch_in stable.
- State RUN:
  - stall_in=0: load all fields from the inputs.
  - valid_out <= ~branch_in.
- State SQUASH (counter k>0):
  - stall_in=0: load pc/instr fields, force valid_out <= 0, decrement k.
  - k reaching 0 returns to RUN.
- stall_in=1 with flush_in=0:
  - All outputs hold, including valid_out.
  - The counter does not decrement; the state does not change.
- flush_in=1: highest priority; overrides stall.
  - valid_out <= 0 next edge; k <= SQUASH_DEPTH; state <= SQUASH.
  - Flush while already in SQUASH reloads k (no accumulation).
  - The incoming slot on the flush edge is discarded and does not count against k.
- Field outputs (cond/class/rn/rd/rs/rm/imm12) are decoded from the loaded instr and update whenever instr_out updates, even for bubbles.
  - Consumers qualify them with valid_out.
- Reset asserted mid-operation clears everything immediately to the reset values, regardless of stall or flush.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined:
  - squash_cnt_out increments on each edge where a slot is accepted but forced or left invalid (branch_in=1 or state SQUASH).
  - stall_cnt_out increments on each edge with stall_in=1.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on rst.
- Not defined: both ports are tied to 16'h0000 and no counter flops exist.

Test Plan:
- Reset release, then pc_in=7'd4, instr_in=32'hE0812003, branch_in=0 for 2 cycles:
  - Edge 1: valid_out=0 (post-reset squash).
  - Edge 2: valid_out=1, pc_out=4, cond_out=4'hE, class_out=00, rn_out=1, rd_out=2, rm_out=3.
- RUN, present 32'hE5912004 then assert stall_in for 3 cycles while new inputs are held:
  - Outputs frozen, class_out=01, rd_out=2, valid_out=1 throughout.
  - stall_cnt_out=3 with DECODE_STATS_EN.
- flush_in=1 together with stall_in=1, SQUASH_DEPTH=2:
  - Next edge valid_out=0.
  - Following two unstalled accepts stay invalid; third accept with branch_in=0 gives valid_out=1.
- Flush, one squashed accept, then a second flush:
  - k reloads to 2, giving three total invalid accepts before valid_out=1.
- branch_in=1 with instr 32'hEA000010 in RUN: valid_out=0 but class_out=10, instr_out=32'hEA000010.
- Assert rst mid-SQUASH with stall active: all outputs 0 immediately; after release, first accept is squashed.
